// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the March-style memory BIST controller.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        WR1  = 3'd3,
        RD1  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int unsigned DEF_HOLD_CYC = 2;
    localparam logic [7:0]  DEF_SEED     = 8'hA5;

    function automatic logic phase_is_write(input state_t s);
        return (s == WR0) || (s == WR1);
    endfunction

    function automatic logic phase_is_inv(input state_t s);
        return (s == WR1) || (s == RD1);
    endfunction

    function automatic logic phase_is_active(input state_t s);
        return (s == WR0) || (s == RD0) || (s == WR1) || (s == RD1);
    endfunction

    // Phase order of the march; RD1 completes the run.
    function automatic state_t phase_next(input state_t s);
        state_t n;
        case (s)
            WR0:     n = RD0;
            RD0:     n = WR1;
            WR1:     n = RD1;
            default: n = DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_bist_addr_seq.sv
// Hold-cycle counter and ascending address counter for the BIST sweep.
module mem_bist_addr_seq
    import mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt_c,
    output logic              last_hold,
    output logic              last_addr
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    // Address advances (and wraps) only after the last hold cycle.
    always_comb begin
        hold_d     = hold_q;
        addr_nxt_c = addr;
        if (clear) begin
            hold_d     = '0;
            addr_nxt_c = '0;
        end else if (en) begin
            if (hold_q == HOLD_LAST) begin
                hold_d     = '0;
                addr_nxt_c = addr + ADDR_W'(1);
            end else begin
                hold_d     = hold_q + HOLD_W'(1);
            end
        end
    end

    // Strobes are registered from the next-state values so they line up with addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            addr      <= '0;
            last_hold <= (HOLD_CYC <= 1);
            last_addr <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            addr      <= addr_nxt_c;
            last_hold <= (hold_d == HOLD_LAST);
            last_addr <= (addr_nxt_c == ADDR_LAST);
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style BIST initiator for the 8x8 memory port: write/read pattern, then its inverse.
// Optional first-failure capture enabled by defining MEM_BIST_FAIL_CAPTURE_EN.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 3,
    parameter int unsigned       HOLD_CYC = DEF_HOLD_CYC,
    parameter logic [DATA_W-1:0] SEED     = DATA_W'(DEF_SEED),
    parameter int unsigned       ERR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        return (SEED ^ DATA_W'(a)) ^ {DATA_W{inv}};
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic               busy_d;
    logic               done_d;
    logic               pass_d;
    logic [ERR_W-1:0]   err_d;
    logic               mem_rw_d;
    logic [DATA_W-1:0]  mem_din_d;
    logic               seq_clear;
    logic               seq_en;
    logic               run_start_c;
    logic               capture_c;
    logic [DATA_W-1:0]  exp_c;
    logic               mismatch_c;
    logic [ADDR_W-1:0]  addr_nxt_c;
    logic               last_hold;
    logic               last_addr;

    mem_bist_addr_seq #(
        .ADDR_W   (ADDR_W),
        .HOLD_CYC (HOLD_CYC)
    ) u_addr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (seq_clear),
        .en         (seq_en),
        .addr       (mem_addr),
        .addr_nxt_c (addr_nxt_c),
        .last_hold  (last_hold),
        .last_addr  (last_addr)
    );

    // Read data is judged once per address, on its final hold cycle.
    assign exp_c      = pattern(mem_addr, phase_is_inv(state_q));
    assign mismatch_c = phase_is_active(state_q) && !phase_is_write(state_q) &&
                        last_hold && (mem_dout != exp_c);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        err_d       = err_cnt;
        seq_clear   = 1'b0;
        seq_en      = 1'b0;
        run_start_c = 1'b0;
        capture_c   = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            seq_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = WR0;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        pass_d      = 1'b0;
                        err_d       = '0;
                        seq_clear   = 1'b1;
                        run_start_c = 1'b1;
                    end
                end
                default: begin
                    seq_en = 1'b1;
                    if (mismatch_c) begin
                        capture_c = 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            err_d = err_cnt + ERR_W'(1);
                        end
                    end
                    if (last_hold && last_addr) begin
                        state_d = phase_next(state_q);
                        if (state_q == RD1) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            pass_d = (err_d == '0);
                        end
                    end
                end
            endcase
        end

        mem_rw_d  = phase_is_write(state_d);
        mem_din_d = mem_rw_d ? pattern(addr_nxt_c, phase_is_inv(state_d)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            mem_rw  <= 1'b0;
            mem_din <= '0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
            err_cnt <= err_d;
            mem_rw  <= mem_rw_d;
            mem_din <= mem_din_d;
        end
    end

`ifdef MEM_BIST_FAIL_CAPTURE_EN
    logic fail_seen;

    // First mismatch of a run is kept; later ones are ignored until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (run_start_c) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (capture_c && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_addr <= mem_addr;
            fail_exp  <= exp_c;
            fail_got  <= mem_dout;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = run_start_c ^ capture_c;
    assign fail_addr      = '0;
    assign fail_exp       = '0;
    assign fail_got       = '0;
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with behavioural 8x8 memories and injectable read faults.
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [7:0] mem_dout, mem_din, fail_exp, fail_got;
    logic [2:0] mem_addr, fail_addr;
    logic       mem_rw, busy, done, pass;
    logic [3:0] err_cnt;

    logic       start1, abort1;
    logic [7:0] mem_dout1, mem_din1, fail_exp1, fail_got1;
    logic [2:0] mem_addr1, fail_addr1;
    logic       mem_rw1, busy1, done1, pass1;
    logic [3:0] err_cnt1;

    logic [7:0] mem0 [8];
    logic [7:0] mem1 [8];
    logic [7:0] stuck5_mask;
    logic       stuck_all;
    logic       log_clr;
    logic       wr5_seen;
    logic [7:0] wr5_first, wr5_last;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_addr(mem_addr), .mem_rw(mem_rw), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_exp(fail_exp),
        .fail_got(fail_got)
    );

    mem_bist_ctrl #(.HOLD_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mem_dout(mem_dout1),
        .mem_din(mem_din1), .mem_addr(mem_addr1), .mem_rw(mem_rw1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err_cnt1), .fail_addr(fail_addr1), .fail_exp(fail_exp1),
        .fail_got(fail_got1)
    );

    // Memory models: synchronous write, combinational read with stuck-at-0 faults on read.
    always @(posedge clk) begin
        if (mem_rw) mem0[mem_addr] <= mem_din;
        if (log_clr) begin
            wr5_seen <= 1'b0;
        end else if (mem_rw && mem_addr == 3'd5) begin
            if (!wr5_seen) wr5_first <= mem_din;
            wr5_seen <= 1'b1;
            wr5_last <= mem_din;
        end
    end

    always_comb begin
        mem_dout = mem0[mem_addr];
        if (stuck_all) mem_dout = 8'h00;
        else if (mem_addr == 3'd5) mem_dout = mem_dout & ~stuck5_mask;
    end

    always @(posedge clk) if (mem_rw1) mem1[mem_addr1] <= mem_din1;
    assign mem_dout1 = mem1[mem_addr1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start, then count busy cycles; optionally re-pulse start mid-run.
    task automatic run0(input bit extra_start, output int cyc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
            start = extra_start && (cyc == 10);
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int k;
        int rd_writes;
        int wr_cnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        stuck5_mask = 8'h00; stuck_all = 1'b0; log_clr = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_rw", 32'(mem_rw), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_din", 32'(mem_din), 0);
        check("rst_faddr", 32'(fail_addr), 0);
        rst_n = 1'b1;
        @(negedge clk) log_clr = 1'b0;

        // Fault-free run
        run0(1'b0, cyc);
        check("t1_len", 32'(cyc), 64);
        check("t1_done", 32'(done), 1);
        check("t1_pass", 32'(pass), 1);
        check("t1_err", 32'(err_cnt), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_wr5_seen", 32'(wr5_seen), 1);
        check("t1_wr5_first", 32'(wr5_first), 32'hA0);
        check("t1_wr5_last", 32'(wr5_last), 32'h5F);

        // Bit 3 of address 5 stuck low: only the inverse read fails
        stuck5_mask = 8'h08;
        run0(1'b0, cyc);
        check("t2_err", 32'(err_cnt), 1);
        check("t2_pass", 32'(pass), 0);
        check("t2_done", 32'(done), 1);
`ifdef MEM_BIST_FAIL_CAPTURE_EN
        check("t2_faddr", 32'(fail_addr), 5);
        check("t2_fexp", 32'(fail_exp), 32'h5F);
        check("t2_fgot", 32'(fail_got), 32'h57);
`else
        check("t2_faddr", 32'(fail_addr), 0);
        check("t2_fexp", 32'(fail_exp), 0);
        check("t2_fgot", 32'(fail_got), 0);
`endif

        // Whole array reads zero: counter saturates
        stuck5_mask = 8'h00;
        stuck_all   = 1'b1;
        run0(1'b0, cyc);
        check("t3_len", 32'(cyc), 64);
        check("t3_err", 32'(err_cnt), 15);
        check("t3_pass", 32'(pass), 0);
        check("t3_done", 32'(done), 1);
`ifdef MEM_BIST_FAIL_CAPTURE_EN
        check("t3_faddr", 32'(fail_addr), 0);
        check("t3_fexp", 32'(fail_exp), 32'hA5);
        check("t3_fgot", 32'(fail_got), 0);
`endif
        stuck_all = 1'b0;

        // Abort during WR1 at address 3 (data ~(A5^3) = 59)
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!(busy && mem_rw && mem_addr == 3'd3 && mem_din == 8'h59) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_reach_wr1", 32'(k < 200), 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t4_busy", 32'(busy), 0);
        check("t4_done", 32'(done), 0);
        check("t4_pass", 32'(pass), 0);
        check("t4_rw", 32'(mem_rw), 0);
        check("t4_err_kept", 32'(err_cnt), 0);
        @(negedge clk);
        check("t4_idle", 32'(busy), 0);
        run0(1'b0, cyc);
        check("t4_len", 32'(cyc), 64);
        check("t4_pass2", 32'(pass), 1);
        check("t4_done2", 32'(done), 1);

        // Asynchronous reset in the middle of RD0
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!(busy && !mem_rw && mem_addr == 3'd2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach_rd0", 32'(k < 200), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_addr", 32'(mem_addr), 0);
        check("t5_rw", 32'(mem_rw), 0);
        check("t5_din", 32'(mem_din), 0);
        check("t5_done", 32'(done), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run0(1'b1, cyc);
        check("t5_len", 32'(cyc), 64);
        check("t5_pass", 32'(pass), 1);
        check("t5_done2", 32'(done), 1);

        // Single-cycle hold: 32-cycle run, no writes in read phases
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cyc = 0; rd_writes = 0; wr_cnt = 0;
        while (busy1 && cyc < 200) begin
            if (((cyc / 8) % 2 == 1) && mem_rw1) rd_writes++;
            if (mem_rw1) wr_cnt++;
            cyc++;
            @(negedge clk);
        end
        check("t6_len", 32'(cyc), 32);
        check("t6_rd_writes", 32'(rd_writes), 0);
        check("t6_wr_cnt", 32'(wr_cnt), 16);
        check("t6_pass", 32'(pass1), 1);
        check("t6_done", 32'(done1), 1);
        check("t6_err", 32'(err_cnt1), 0);
        check("t6_faddr", 32'(fail_addr1), 0);
        check("t6_fexp", 32'(fail_exp1), 0);
        check("t6_fgot", 32'(fail_got1), 0);
        check("t6_din_idle", 32'(mem_din1), 0);
        check("t6_addr_idle", 32'(mem_addr1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
